nios_system_button_debouncer: RTL and testbench

Synchronises and debounces the raw board pushbutton pins and drives the clean levels into the pushbutton PIO's `in_port`. The PIO's falling-edge capture and IRQ logic therefore sees exactly one edge per physical press. The block also exposes a small Avalon-MM slave with:
- raw and debounced readback;
- a programmable debounce threshold;
- sticky glitch flags.

---
 rtl/nios_system_button_debouncer.sv | 146 ++++++++++++++
 tb/tb_nios_system_button_debouncer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_button_debouncer.sv
// Pushbutton synchroniser/debouncer feeding the PIO in_port, with an Avalon-MM
// slave for raw/debounced readback, a programmable threshold and sticky glitch flags.
module nios_system_button_debouncer #(
    parameter int WIDTH           = 4,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] button_pins,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] THR_RESET = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] debounced_q, debounced_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] glitch_q, glitch_d;
    logic [WIDTH-1:0] glitch_set_s;
    logic [WIDTH-1:0] glitch_clr_s;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] thr_eff_s;
    logic [CNT_W-1:0] thr_lim_s;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_s;
    logic             wr_thr_s;
    logic             wr_glitch_s;
    logic             wdata_unused_s;

    assign wdata_unused_s = ^writedata[31:CNT_W];

    // Bus write decode and effective threshold (zero behaves as one)
    always_comb begin
        wr_s        = chipselect & ~write_n;
        wr_thr_s    = wr_s && (address == 2'd2);
        wr_glitch_s = wr_s && (address == 2'd3);
        if (thr_q == '0) begin
            thr_eff_s = CNT_ONE;
        end else begin
            thr_eff_s = thr_q;
        end
        thr_lim_s = thr_eff_s - CNT_ONE;
    end

    // Two-flop synchroniser for the asynchronous pins
    always_comb begin
        sync1_d = button_pins;
        sync2_d = sync1_q;
    end

    // Per-channel debounce counters, level update, edge pulses and glitch detection
    always_comb begin
        debounced_d  = debounced_q;
        glitch_set_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == debounced_q[i]) begin
                // agreement with a non-zero count means a bounce was just rejected
                cnt_d[i]        = '0;
                glitch_set_s[i] = (cnt_q[i] != '0);
            end else if (cnt_q[i] >= thr_lim_s) begin
                debounced_d[i] = sync2_q[i];
                cnt_d[i]       = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        press_d   = debounced_q & ~debounced_d;
        release_d = ~debounced_q & debounced_d;
    end

    // Register-file updates: threshold write and write-1-to-clear glitch (set wins)
    always_comb begin
        if (wr_thr_s) begin
            thr_d = writedata[CNT_W-1:0];
        end else begin
            thr_d = thr_q;
        end
        if (wr_glitch_s) begin
            glitch_clr_s = writedata[WIDTH-1:0];
        end else begin
            glitch_clr_s = '0;
        end
        glitch_d = (glitch_q & ~glitch_clr_s) | glitch_set_s;
    end

    // Read mux, registered every cycle regardless of chipselect
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = sync2_q;
            2'd1:    readdata_d[WIDTH-1:0] = debounced_q;
            2'd2:    readdata_d[CNT_W-1:0] = thr_q;
            2'd3:    readdata_d[WIDTH-1:0] = glitch_q;
            default: readdata_d = '0;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            debounced_q <= '1;
            press_q     <= '0;
            release_q   <= '0;
            glitch_q    <= '0;
            thr_q       <= THR_RESET;
            readdata_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            debounced_q <= debounced_d;
            press_q     <= press_d;
            release_q   <= release_d;
            glitch_q    <= glitch_d;
            thr_q       <= thr_d;
            readdata_q  <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata      = readdata_q;
    assign debounced     = debounced_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_nios_system_button_debouncer.sv
// Bench for nios_system_button_debouncer: directed timing scenarios plus a
// randomized run checked against a timestamp-based reference model.
module tb_nios_system_button_debouncer;

    localparam int W  = 4;
    localparam int CW = 20;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  button_pins;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  debounced;
    logic [W-1:0]  press_pulse;
    logic [W-1:0]  release_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    nios_system_button_debouncer #(.WIDTH(W), .CNT_W(CW), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset_n(reset_n), .button_pins(button_pins), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .debounced(debounced), .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: a channel toggles once sync2 has disagreed with the clean
    // level for thr_eff consecutive cycles, measured from the cycle it started.
    logic [W-1:0]  m_s1, m_s2, m_deb, m_press, m_rel, m_glitch;
    logic [CW-1:0] m_thr;
    logic [31:0]   m_rd;
    int            m_cyc;
    int            m_since [W];

    always @(posedge clk or negedge reset_n) begin : ref_model
        int te;
        int since_n [W];
        logic [W-1:0] nd, ng;
        logic [31:0] rd;
        if (!reset_n) begin
            m_s1 <= '1; m_s2 <= '1; m_deb <= '1; m_press <= '0; m_rel <= '0;
            m_glitch <= '0; m_thr <= CW'(DB); m_rd <= '0; m_cyc <= 0;
            for (int i = 0; i < W; i++) m_since[i] <= -1;
        end else begin
            te = (m_thr == '0) ? 1 : int'(m_thr);
            nd = m_deb;
            ng = m_glitch;
            if (chipselect && !write_n && address == 2'd3) ng = ng & ~writedata[W-1:0];
            for (int i = 0; i < W; i++) begin
                since_n[i] = -1;
                if (m_s2[i] != m_deb[i]) begin
                    since_n[i] = (m_since[i] < 0) ? m_cyc : m_since[i];
                    if (m_cyc - since_n[i] + 1 >= te) begin
                        nd[i] = m_s2[i];
                        since_n[i] = -1;
                    end
                end else if (m_since[i] >= 0) begin
                    ng[i] = 1'b1;
                end
            end
            rd = 32'd0;
            if (address == 2'd0) rd = 32'(m_s2);
            else if (address == 2'd1) rd = 32'(m_deb);
            else if (address == 2'd2) rd = 32'(m_thr);
            else rd = 32'(m_glitch);
            m_rd <= rd;
            m_press <= m_deb & ~nd;
            m_rel <= ~m_deb & nd;
            m_deb <= nd;
            m_glitch <= ng;
            if (chipselect && !write_n && address == 2'd2) m_thr <= writedata[CW-1:0];
            m_s2 <= m_s1;
            m_s1 <= button_pins;
            m_cyc <= m_cyc + 1;
            for (int i = 0; i < W; i++) m_since[i] <= since_n[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            button_pins = 4'($urandom);
            address = 2'($urandom);
            tick();
            n_tests++;
            if (debounced !== 4'hF || press_pulse !== 4'h0 || release_pulse !== 4'h0 || readdata !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d: got deb=%h prs=%h rel=%h rd=%h expected F/0/0/0",
                         k, debounced, press_pulse, release_pulse, readdata);
            end
        end
        button_pins = 4'hF;
        address = 2'd2;
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (readdata !== 32'd8) begin
            n_fail++;
            $display("FAIL reset_thr: got %0d expected 8", readdata);
        end
        tick();
    endtask

    task automatic test_clean_press();
        logic [W-1:0] exp_deb;
        button_pins = 4'hE;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_deb = (k >= 10) ? 4'hE : 4'hF;
            n_tests++;
            if (debounced !== exp_deb || press_pulse !== ((k == 10) ? 4'h1 : 4'h0) || release_pulse !== 4'h0) begin
                n_fail++;
                $display("FAIL clean_press k=%0d: got deb=%h prs=%h rel=%h expected deb=%h prs=%h",
                         k, debounced, press_pulse, release_pulse, exp_deb, (k == 10) ? 4'h1 : 4'h0);
            end
        end
        button_pins = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_deb = (k >= 10) ? 4'hF : 4'hE;
            n_tests++;
            if (debounced !== exp_deb || release_pulse !== ((k == 10) ? 4'h1 : 4'h0) || press_pulse !== 4'h0) begin
                n_fail++;
                $display("FAIL clean_release k=%0d: got deb=%h rel=%h prs=%h expected deb=%h rel=%h",
                         k, debounced, release_pulse, press_pulse, exp_deb, (k == 10) ? 4'h1 : 4'h0);
            end
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] exp_deb;
        button_pins = 4'hD;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_deb = (k >= 18) ? 4'hD : 4'hF;
            n_tests++;
            if (debounced !== exp_deb || press_pulse !== ((k == 18) ? 4'h2 : 4'h0)) begin
                n_fail++;
                $display("FAIL bounce k=%0d: got deb=%h prs=%h expected deb=%h prs=%h",
                         k, debounced, press_pulse, exp_deb, (k == 18) ? 4'h2 : 4'h0);
            end
            if (k == 5) button_pins = 4'hF;
            if (k == 8) button_pins = 4'hD;
        end
        address = 2'd3;
        tick();
        n_tests++;
        if (readdata !== 32'h2) begin
            n_fail++;
            $display("FAIL glitch_set: got %h expected 2", readdata);
        end
        bus_write(2'd3, 32'h2);
        address = 2'd3;
        tick();
        n_tests++;
        if (readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_clear: got %h expected 0", readdata);
        end
        button_pins = 4'hF;
        wait_cycles(12);
    endtask

    task automatic test_threshold_edges();
        logic [W-1:0] exp_deb;
        bus_write(2'd2, 32'd0);
        button_pins = 4'hB;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_deb = (k >= 3) ? 4'hB : 4'hF;
            n_tests++;
            if (debounced !== exp_deb || press_pulse !== ((k == 3) ? 4'h4 : 4'h0)) begin
                n_fail++;
                $display("FAIL thr_zero k=%0d: got deb=%h prs=%h expected deb=%h", k, debounced, press_pulse, exp_deb);
            end
        end
        button_pins = 4'hF;
        wait_cycles(4);
        bus_write(2'd2, 32'd8);
        button_pins = 4'h7;
        wait_cycles(7);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'd3;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        n_tests++;
        if (debounced !== 4'hF || press_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL thr_change_early: got deb=%h prs=%h expected F/0", debounced, press_pulse);
        end
        tick();
        n_tests++;
        if (debounced !== 4'h7 || press_pulse !== 4'h8) begin
            n_fail++;
            $display("FAIL thr_change_toggle: got deb=%h prs=%h expected 7/8", debounced, press_pulse);
        end
        bus_write(2'd2, 32'd8);
        button_pins = 4'hF;
        wait_cycles(12);
        n_tests++;
        if (debounced !== 4'hF) begin
            n_fail++;
            $display("FAIL thr_restore: got deb=%h expected F", debounced);
        end
    endtask

    task automatic test_simultaneous();
        button_pins = 4'h6;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_tests++;
            if (press_pulse !== ((k == 10) ? 4'h9 : 4'h0) || debounced !== ((k >= 10) ? 4'h6 : 4'hF)) begin
                n_fail++;
                $display("FAIL simul_press k=%0d: got prs=%h deb=%h", k, press_pulse, debounced);
            end
        end
        button_pins = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_tests++;
            if (release_pulse !== ((k == 10) ? 4'h9 : 4'h0)) begin
                n_fail++;
                $display("FAIL simul_release k=%0d: got rel=%h expected %h", k, release_pulse, (k == 10) ? 4'h9 : 4'h0);
            end
        end
        address = 2'd3;
        tick();
        n_tests++;
        if (readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_pre: got %h expected 0", readdata);
        end
        button_pins = 4'hD;
        wait_cycles(3);
        button_pins = 4'hF;
        wait_cycles(2);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h2;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        tick();
        n_tests++;
        if (readdata !== 32'h2 || press_pulse !== 4'h0 || debounced !== 4'hF) begin
            n_fail++;
            $display("FAIL glitch_set_wins: got rd=%h prs=%h deb=%h expected 2/0/F", readdata, press_pulse, debounced);
        end
        bus_write(2'd3, 32'hF);
        wait_cycles(2);
    endtask

    task automatic test_midcount_reset();
        button_pins = 4'hE;
        wait_cycles(8);
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (debounced !== 4'hF || press_pulse !== 4'h0 || release_pulse !== 4'h0) begin
                n_fail++;
                $display("FAIL midreset_hold k=%0d: got deb=%h prs=%h rel=%h", k, debounced, press_pulse, release_pulse);
            end
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_tests++;
            if (debounced !== ((k >= 10) ? 4'hE : 4'hF) || press_pulse !== ((k == 10) ? 4'h1 : 4'h0)) begin
                n_fail++;
                $display("FAIL midreset_restart k=%0d: got deb=%h prs=%h", k, debounced, press_pulse);
            end
        end
        button_pins = 4'hF;
        wait_cycles(12);
    endtask

    task automatic test_random();
        int op;
        bus_write(2'd2, 32'd3);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 9) == 0) button_pins[i] = ~button_pins[i];
            end
            op = int'($urandom_range(0, 15));
            chipselect = 1'b0; write_n = 1'b1;
            address = 2'($urandom);
            writedata = $urandom;
            if (op == 0) begin
                chipselect = 1'b1; write_n = 1'b0; address = 2'd2;
                writedata = 32'($urandom_range(0, 6));
            end else if (op == 1) begin
                chipselect = 1'b1; write_n = 1'b0; address = 2'd3;
            end else if (op == 2) begin
                chipselect = 1'b1; write_n = 1'b0; address = 2'($urandom_range(0, 1));
            end else if (op == 3) begin
                chipselect = 1'b1;
            end
            tick();
            n_tests++;
            if (debounced !== m_deb || press_pulse !== m_press || release_pulse !== m_rel || readdata !== m_rd) begin
                n_fail++;
                $display("FAIL random c=%0d: got deb=%h prs=%h rel=%h rd=%h expected deb=%h prs=%h rel=%h rd=%h",
                         c, debounced, press_pulse, release_pulse, readdata, m_deb, m_press, m_rel, m_rd);
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        button_pins = 4'hF;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'd0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_threshold_edges();
        test_simultaneous();
        test_midcount_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
